// File: rtl/dffer_pipe.sv
// dffer_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Each stage carries a valid bit; a combinational ready chain lets bubbles
// collapse so the chain only stalls where a valid item cannot move forward.
// Global enable E freezes everything; flush drops all in-flight items.
module dffer_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         R,
    input  logic                         E,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    // rdy[i]: stage i may load from upstream this cycle; rdy[DEPTH] is the sink.
    logic [DEPTH:0]   rdy;
    logic             in_xfer;
    logic             out_xfer;

    // Ready chain built back-to-front through a scalar so there is no
    // self-referencing vector in the combinational loop.
    always_comb begin
        logic chain;
        chain      = out_ready;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = ~valid_q[i] | chain;
            rdy[i] = chain;
        end
    end

    // Handshake outputs; enable gates both ends so a frozen pipe is invisible.
    always_comb begin
        in_ready  = rdy[0] & E & ~flush;
        out_valid = valid_q[DEPTH-1] & E;
        out_data  = data_q[DEPTH-1];
        count     = count_q;
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
    end

    // Next-state: flush clears valids only, enable shifts every ready stage.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else if (E) begin
            if (rdy[0]) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
            case ({in_xfer, out_xfer})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset reloads data stages so out_data is defined.
    always_ff @(posedge clk) begin
        if (R) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dffer_pipe.sv
// Directed bench for dffer_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0x5A).
module tb_dffer_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       R = 1'b1;
    logic       E = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    dffer_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk(clk), .R(R), .E(E), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        R = 1'b1; E = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        R = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL rst_out_data got %h exp %h", out_data, RV); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 1'b0;
    endtask

    // Items 0x01..0x08 accepted in cycles 0..7; item k emerges in cycle k+3.
    task automatic test_stream;
        int exp_cnt;
        out_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            in_valid = (c < 8);
            in_data  = 8'(c + 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b exp 1", c, in_ready); end
            if (c >= 4 && c < 12) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'(c - 3)) begin errors++; $display("FAIL stream_out c=%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, out_data, 8'(c - 3)); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d got v=%b exp 0", c, out_valid); end
            end
            exp_cnt = (c < 8 ? c : 8) - (c < 4 ? 0 : (c - 4 > 8 ? 8 : c - 4));
            checks++; if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL stream_count c=%0d got %0d exp %0d", c, count, exp_cnt); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full;
        logic [7:0] exp_q [4];
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(c < 4 ? c : 4);
            #1;
            checks++; if (in_ready !== (c < 4)) begin errors++; $display("FAIL full_in_ready c=%0d got %b exp %b", c, in_ready, (c < 4)); end
            tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin errors++; $display("FAIL full_head got v=%b d=%h exp v=1 d=a0", out_valid, out_data); end
        // Full and ready: simultaneous in/out.
        out_ready = 1'b1;
        in_data = 8'hA4;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_in_ready got %b exp 1", in_ready); end
        checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL full_pass_out got %h exp a0", out_data); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pass_count got %0d exp 4", count); end
        in_data = 8'hA5;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL full_order got v=%b d=%h exp v=1 d=a1", out_valid, out_data); end
        tick();
        in_valid = 1'b0;
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin errors++; $display("FAIL full_drain k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_q[k]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_empty got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count); end
    endtask

    task automatic test_bubble;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'h22; tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL bubble_count got %0d exp 2", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bubble_head got v=%b d=%h exp v=1 d=11", out_valid, out_data); end
        out_ready = 1'b1;
        #1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bubble_second got v=%b d=%h exp v=1 d=22", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL bubble_empty got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count); end
    endtask

    // E low in cycles 5..7; six items 0x31..0x36, out_ready held high.
    task automatic test_enable;
        logic [7:0] exp_out [14];
        int ptr;
        exp_out = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h31, 8'h00, 8'h00, 8'h00,
                    8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h00};
        ptr = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            E = !(c >= 5 && c <= 7);
            in_valid = E && (ptr < 6);
            in_data = 8'h31 + 8'(ptr);
            #1;
            checks++; if (in_ready !== E) begin errors++; $display("FAIL en_in_ready c=%0d got %b exp %b", c, in_ready, E); end
            if (exp_out[c] != 8'h00) begin
                checks++; if (out_valid !== 1'b1 || out_data !== exp_out[c]) begin errors++; $display("FAIL en_out c=%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, out_data, exp_out[c]); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_idle c=%0d got v=%b exp 0", c, out_valid); end
            end
            if (!E) begin
                checks++; if (count !== 3'd4 || out_data !== 8'h32) begin errors++; $display("FAIL en_frozen c=%0d got cnt=%0d d=%h exp cnt=4 d=32", c, count, out_data); end
            end
            if (in_valid) ptr++;
            tick();
        end
        E = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h41 + 8'(k); tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL flush_head got v=%b d=%h exp v=1 d=41", out_valid, out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid); end
        checks++; if (out_data !== 8'h41) begin errors++; $display("FAIL flush_data_kept got %h exp 41", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_resume_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'h51 + 8'(k); tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL rmid_pre_count got %0d exp 4", count); end
        R = 1'b1; out_ready = 1'b1;
        tick();
        R = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL rmid_out_data got %h exp %h", out_data, RV); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_bubble();
        test_enable();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
